// File: rtl/rom_fetch_unit.sv
// Instruction-fetch stage for a 1-cycle synchronous program ROM: PC, in-flight tracking,
// opcode/operand split and a 1-entry skid buffer behind a valid/ready output.
module rom_fetch_unit #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [AW-1:0]   load_addr,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW/2-1:0] out_opcode,
  output logic [DW/2-1:0] out_operand,
  output logic [AW-1:0]   out_pc
);

  localparam int unsigned HW = DW / 2;

  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_word_q, skid_word_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_word_q, out_word_d;
  logic [AW-1:0] out_pc_q, out_pc_d;

  logic accept;
  logic out_free;
  logic issue;

  always_comb begin
    accept   = out_valid_q && out_ready;
    out_free = !out_valid_q || accept;
    // Never issue a read whose data could find both out and skid occupied.
    issue    = enable && !load && !skid_valid_q &&
               !(inflight_q && out_valid_q && !out_ready);

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_word_d   = skid_word_q;
    skid_pc_d     = skid_pc_q;
    out_valid_d   = out_valid_q;
    out_word_d    = out_word_q;
    out_pc_d      = out_pc_q;

    if (issue) begin
      pc_d          = pc_q + AW'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (accept) begin
      out_valid_d = 1'b0;
    end

    if (skid_valid_q && out_free) begin
      out_valid_d  = 1'b1;
      out_word_d   = skid_word_q;
      out_pc_d     = skid_pc_q;
      skid_valid_d = 1'b0;
    end

    if (inflight_q) begin
      if (out_free && !skid_valid_q) begin
        out_valid_d = 1'b1;
        out_word_d  = rom_data;
        out_pc_d    = inflight_pc_q;
      end else begin
        skid_valid_d = 1'b1;
        skid_word_d  = rom_data;
        skid_pc_d    = inflight_pc_q;
      end
    end

    // Jump flushes the pipeline; any word landing this edge is dropped.
    if (load) begin
      pc_d         = load_addr;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_word_q   <= '0;
      skid_pc_q     <= '0;
      out_valid_q   <= 1'b0;
      out_word_q    <= '0;
      out_pc_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_word_q   <= skid_word_d;
      skid_pc_q     <= skid_pc_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      out_pc_q      <= out_pc_d;
    end
  end

  always_comb begin
    rom_addr    = pc_q;
    out_valid   = out_valid_q;
    out_opcode  = out_word_q[DW-1:HW];
    out_operand = out_word_q[HW-1:0];
    out_pc      = out_pc_q;
  end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit with AW=4 and a registered ROM holding rom[i] = i + 8'h10.
module tb_rom_fetch_unit;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          load;
  logic [AW-1:0] load_addr;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_opcode;
  logic [3:0]    out_operand;
  logic [AW-1:0] out_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] rom_mem [16];

  rom_fetch_unit #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_addr  (load_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_operand(out_operand),
    .out_pc     (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every ROM word is 0x1n, so opcode is always 1 and operand equals the fetch address.
  task automatic expect_out(input string tag, input logic v, input logic [3:0] pc);
    chk({tag, ".valid"}, 16'(out_valid), 16'(v));
    if (v) begin
      chk({tag, ".pc"}, 16'(out_pc), 16'(pc));
      chk({tag, ".opcode"}, 16'(out_opcode), 16'h1);
      chk({tag, ".operand"}, 16'(out_operand), 16'(pc));
    end
  endtask

  logic       en_tab [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 0};
  logic       v_tab  [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
  logic [3:0] pc_tab [10] = '{0, 0, 1, 0, 0, 2, 3, 0, 0, 4};

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i + 16);
    reset     = 1'b1;
    enable    = 1'b0;
    load      = 1'b0;
    load_addr = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst.valid", 16'(out_valid), 16'h0);
    chk("rst.pc", 16'(out_pc), 16'h0);
    chk("rst.opcode", 16'(out_opcode), 16'h0);
    chk("rst.operand", 16'(out_operand), 16'h0);
    chk("rst.rom_addr", 16'(rom_addr), 16'h0);

    // Streaming from reset: first word appears at the second edge.
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    tick();
    expect_out("e1", 1'b0, 4'd0);
    chk("e1.rom_addr", 16'(rom_addr), 16'h1);
    tick(); expect_out("e2", 1'b1, 4'd0);
    tick(); expect_out("e3", 1'b1, 4'd1);
    tick(); expect_out("e4", 1'b1, 4'd2);
    tick(); expect_out("e5", 1'b1, 4'd3);

    // Stall four edges: out holds pc3, pc4 parks in skid, PC frozen at 5.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("stall", 1'b1, 4'd3);
      chk("stall.rom_addr", 16'(rom_addr), 16'h5);
    end
    out_ready = 1'b1;
    tick(); expect_out("rel1", 1'b1, 4'd4);
    chk("rel1.rom_addr", 16'(rom_addr), 16'h5);
    tick(); expect_out("rel2", 1'b0, 4'd0);
    tick(); expect_out("rel3", 1'b1, 4'd5);
    tick(); expect_out("rel4", 1'b1, 4'd6);

    // Wrap: keep streaming until the PC rolls over.
    for (int i = 0; i < 7; i++) tick();
    chk("wrap.rom15", 16'(rom_addr), 16'hF);
    tick();
    chk("wrap.rom0", 16'(rom_addr), 16'h0);
    tick(); expect_out("wrap15", 1'b1, 4'd15);
    tick(); expect_out("wrap0", 1'b1, 4'd0);

    // Jump while pc6 is in flight and out holds pc5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    expect_out("pre_jump", 1'b1, 4'd5);
    load = 1'b1; load_addr = 4'd12;
    tick();
    load = 1'b0;
    expect_out("jump1", 1'b0, 4'd0);
    chk("jump1.rom_addr", 16'(rom_addr), 16'hC);
    tick(); expect_out("jump2", 1'b0, 4'd0);
    chk("jump2.rom_addr", 16'(rom_addr), 16'hD);
    tick(); expect_out("jump3", 1'b1, 4'd12);
    tick(); expect_out("jump4", 1'b1, 4'd13);

    // Fill the skid, then reset with the output stalled.
    out_ready = 1'b0;
    tick();
    expect_out("skidfull", 1'b1, 4'd13);
    chk("skidfull.rom_addr", 16'(rom_addr), 16'hF);
    reset = 1'b1;
    tick();
    chk("mrst.valid", 16'(out_valid), 16'h0);
    chk("mrst.pc", 16'(out_pc), 16'h0);
    chk("mrst.opcode", 16'(out_opcode), 16'h0);
    chk("mrst.operand", 16'(out_operand), 16'h0);
    chk("mrst.rom_addr", 16'(rom_addr), 16'h0);
    reset = 1'b0; out_ready = 1'b1;
    tick(); expect_out("post1", 1'b0, 4'd0);
    tick(); expect_out("post2", 1'b1, 4'd0);

    // Enable toggled 1-1-0-0: gaps follow the low cycles one edge later.
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      enable = en_tab[k];
      tick();
      expect_out("entog", v_tab[k], pc_tab[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Instruction-fetch stage that drives the address port of the synchronous program ROM (memRom, 1-cycle registered read) and consumes its data output.
- Holds the program counter, issues one address per cycle, and tracks the in-flight read.
- Splits each returned word into opcode and operand nibbles and presents them downstream through a valid/ready handshake.
- Includes a 1-entry skid buffer so downstream stalls never lose a ROM word.

Parameters:
- AW, 12, program-counter and ROM address width; must match the ROM's AW.
- DW, 8, ROM data width; must be even; opcode = upper DW/2 bits, operand = lower DW/2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  Synchronous, active-high reset.
- enable  in  1  allows address issue; when low, no new addresses are issued and in-flight data still lands.
- load  in  1  jump request: PC <= load_addr and pipeline flush.
- load_addr  in  AW  jump target.
- rom_addr  out  AW  address to ROM; equals PC register (combinational from register).
- rom_data  in  DW  ROM output; valid in the cycle after an issue edge.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready at rising edge.
- out_opcode  out  DW/2  rom_data[DW-1:DW/2] of current word.
- out_operand  out  DW/2  rom_data[DW/2-1:0] of current word.
- out_pc  out  AW  address the current word was fetched from.

Behaviour:
- Reset (sync, wins over everything): pc=0, inflight=0, skid_valid=0, out_valid=0, out_opcode/out_operand/out_pc=0.
- issue = enable && !load && !skid_valid && !(inflight && out_valid && !out_ready).
- On issue edge: pc <= pc+1 (mod 2^AW, so 2^AW-1 wraps to 0); inflight <= 1; inflight_pc <= pc. Otherwise inflight <= 0.
- Landing (inflight=1, rom_data valid this cycle), at the edge:
  - If out register is free (out_valid=0 or accepted this edge) and skid is empty: word goes to out register.
  - Else: word goes to skid with inflight_pc.
- Skid drain: when skid_valid and out register is accepted, skid moves to out in the same edge; skid_valid <= 0. Same-edge landing + drain: skid→out and landing→skid. The issue rule guarantees no third word.
- out_valid drops after acceptance only if nothing moves in; it holds, and data is stable, while out_valid && !out_ready.
- Latency: address presented in cycle k and latched at edge k → out_valid at edge k+1. Throughput is 1 word/clk with out_ready=1.
- load (enable-independent, lower priority than reset only):
  - At the edge: pc <= load_addr; inflight, skid_valid, out_valid <= 0 (flush; the landing word is discarded).
  - Next cycle: rom_addr = load_addr; issue resumes normally.
- enable low: PC frozen; in-flight word still lands; out contents held until accepted.

Test Plan:
- Bench ROM model is memRom behaviour with rom[i] = i+8'h10, AW=4 in bench.
- Reset then enable=1, out_ready=1 → out_valid rises at 2nd edge after reset release; sequence (pc,opcode,operand) = (0,1,0),(1,1,1),(2,1,2)…, one per clock, no gaps.
- Stall: after word pc=3 valid, hold out_ready=0 for 4 cycles → out holds pc=3 (0x13); skid captures pc=4; rom_addr frozen at 5. Release → pc=4 then 5, 6 consecutive, nothing lost or duplicated.
- Wrap: AW=4, run past pc=15 → word pc=15 (0x1F) then pc=0 (0x10); rom_addr wraps 15→0.
- Jump mid-stream: while pc=6 is in flight and out holds pc=5, pulse load=1 with load_addr=12 → pc=5 and pc=6 are never presented after the edge; next outputs are pc=12 (0x1C), 13.
- Reset mid-operation with skid full and out_ready=0 → the next edge clears all valids and outputs to 0, rom_addr=0; first post-reset word is pc=0.
- enable toggled 1-0-1 every 2 cycles with out_ready=1 → outputs are strictly consecutive addresses; out_valid gaps match enable-low cycles delayed by 1.
